// File: rtl/fifo_switch_harness.sv
// fifo_switch_harness: board-level FIFO exerciser.
// Two bouncing push-switches are synchronised and debounced into one-cycle
// read/write ticks. A write tick pushes the synchronised switch word into a
// 2**W-deep show-ahead FIFO. The FIFO state is presented on LEDs.
// Optional feature: define FIFO_HARNESS_ERR_EN to build the sticky ovf/udf
// flags. Without it, both flags are tied low.

// Debouncer plus rising-edge detector for one synchronised control switch.
module fifo_switch_debounce #(
  parameter int DB_N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_sync,
  output logic tick
);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} db_state_t;

  localparam logic [DB_N-1:0] CNT_MAX  = {DB_N{1'b1}};
  localparam logic [DB_N-1:0] CNT_ZERO = {DB_N{1'b0}};
  localparam logic [DB_N-1:0] CNT_ONE  = DB_N'(1);

  db_state_t       state_r;
  db_state_t       state_next_s;
  db_state_t       prev_r;
  logic [DB_N-1:0] cnt_r;
  logic [DB_N-1:0] cnt_next_s;

  // State, stability counter, previous state and press-edge strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= LOW;
      prev_r  <= LOW;
      cnt_r   <= CNT_ZERO;
      tick    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      prev_r  <= state_r;
      cnt_r   <= cnt_next_s;
      tick    <= (state_r == HIGH) && (prev_r == LOW);
    end
  end

  // Flip state only after the input has differed for 2**DB_N cycles.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = CNT_ZERO;
    case (state_r)
      LOW: begin
        if (sw_sync) begin
          if (cnt_r == CNT_MAX) begin
            state_next_s = HIGH;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_next_s = CNT_ZERO;
        end
      end
      HIGH: begin
        if (!sw_sync) begin
          if (cnt_r == CNT_MAX) begin
            state_next_s = LOW;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_next_s = CNT_ZERO;
        end
      end
      default: begin
        state_next_s = LOW;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

endmodule

module fifo_switch_harness #(
  parameter int B    = 6,
  parameter int W    = 3,
  parameter int DB_N = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw_rd,
  input  logic         sw_wr,
  input  logic [B-1:0] sw_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  output logic         rd_tick,
  output logic         wr_tick,
  output logic         ovf,
  output logic         udf
);

  localparam int          DEPTH    = 2 ** W;
  localparam logic [W:0]  FULL_CNT = {1'b1, {W{1'b0}}};
  localparam logic [W:0]  CNT_ZERO = {(W+1){1'b0}};
  localparam logic [W:0]  CNT_ONE  = (W+1)'(1);
  localparam logic [W-1:0] PTR_ZERO = {W{1'b0}};
  localparam logic [W-1:0] PTR_ONE  = W'(1);

  logic         rd_s1_r, rd_s2_r;
  logic         wr_s1_r, wr_s2_r;
  logic [B-1:0] data_s1_r, data_s2_r;

  logic [B-1:0] mem_r [0:DEPTH-1];
  logic [W-1:0] rd_ptr_r;
  logic [W-1:0] wr_ptr_r;
  logic [W:0]   count_r;

  logic         do_wr_s;
  logic         do_rd_s;
  logic [W:0]   count_next_s;

  // Two-flop synchronisers for every raw switch input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_s1_r   <= 1'b0;
      rd_s2_r   <= 1'b0;
      wr_s1_r   <= 1'b0;
      wr_s2_r   <= 1'b0;
      data_s1_r <= {B{1'b0}};
      data_s2_r <= {B{1'b0}};
    end else begin
      rd_s1_r   <= sw_rd;
      rd_s2_r   <= rd_s1_r;
      wr_s1_r   <= sw_wr;
      wr_s2_r   <= wr_s1_r;
      data_s1_r <= sw_data;
      data_s2_r <= data_s1_r;
    end
  end

  fifo_switch_debounce #(.DB_N(DB_N)) u_db_rd (
    .clk     (clk),
    .reset   (reset),
    .sw_sync (rd_s2_r),
    .tick    (rd_tick)
  );

  fifo_switch_debounce #(.DB_N(DB_N)) u_db_wr (
    .clk     (clk),
    .reset   (reset),
    .sw_sync (wr_s2_r),
    .tick    (wr_tick)
  );

  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == FULL_CNT);
  assign count = count_r;

  // Decide which FIFO operations execute; a read frees the slot when full.
  always_comb begin
    do_rd_s      = 1'b0;
    do_wr_s      = 1'b0;
    count_next_s = count_r;
    do_rd_s = rd_tick & ~empty;
    do_wr_s = wr_tick & (~full | do_rd_s);
    case ({do_wr_s, do_rd_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= data_s2_r;
    end
  end

  assign r_data = empty ? {B{1'b0}} : mem_r[rd_ptr_r];

`ifdef FIFO_HARNESS_ERR_EN
  logic ovf_r;
  logic udf_r;
  logic ovf_set_s;
  logic udf_set_s;

  assign ovf_set_s = wr_tick & full & ~rd_tick;
  assign udf_set_s = rd_tick & empty;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
      if (udf_set_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  assign ovf = ovf_r;
  assign udf = udf_r;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_switch_harness.sv
// Directed bench for fifo_switch_harness with B=6, W=3, DB_N=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_switch_harness;

  logic       clk;
  logic       reset;
  logic       sw_rd;
  logic       sw_wr;
  logic [5:0] sw_data;
  logic [5:0] r_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       rd_tick;
  logic       wr_tick;
  logic       ovf;
  logic       udf;

  int vectors;
  int miscompares;
  int rd_seen;
  int wr_seen;
  int both_seen;

`ifdef FIFO_HARNESS_ERR_EN
  localparam logic FLAG_EXP = 1'b1;
`else
  localparam logic FLAG_EXP = 1'b0;
`endif

  fifo_switch_harness #(.B(6), .W(3), .DB_N(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_rd   (sw_rd),
    .sw_wr   (sw_wr),
    .sw_data (sw_data),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .rd_tick (rd_tick),
    .wr_tick (wr_tick),
    .ovf     (ovf),
    .udf     (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and tally any ticks seen there.
  task automatic step();
    @(negedge clk);
    if (rd_tick) rd_seen++;
    if (wr_tick) wr_seen++;
    if (rd_tick && wr_tick) both_seen++;
  endtask

  task automatic clear_seen();
    rd_seen = 0;
    wr_seen = 0;
    both_seen = 0;
  endtask

  // Clean press and release of the selected switches.
  task automatic press(input logic do_rd, input logic do_wr, input logic [5:0] data);
    clear_seen();
    sw_data = data;
    sw_rd = do_rd;
    sw_wr = do_wr;
    repeat (12) step();
    sw_rd = 1'b0;
    sw_wr = 1'b0;
    repeat (12) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw_rd = 1'b0;
    sw_wr = 1'b0;
    sw_data = 6'h00;
    repeat (3) step();
    reset = 1'b0;
    clear_seen();
    repeat (8) step();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (r_data !== 6'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", r_data); end
    vectors++; if ((rd_seen + wr_seen) !== 0) begin miscompares++; $display("FAIL reset_ticks: got %0d want 0", rd_seen + wr_seen); end
    vectors++; if ({ovf, udf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {ovf, udf}); end
  endtask

  // Tick must be high only in the cycle after capture edge + 6.
  task automatic test_latency();
    sw_data = 6'h15;
    sw_wr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (wr_tick !== (k == 6)) begin
        miscompares++;
        $display("FAIL latency_tick k=%0d: got %b want %b", k, wr_tick, (k == 6));
      end
      if (k == 7) begin
        vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL latency_count: got %0d want 1", count); end
        vectors++; if (r_data !== 6'h15) begin miscompares++; $display("FAIL latency_rdata: got %h want 15", r_data); end
      end
    end
    sw_wr = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_glitch();
    clear_seen();
    sw_data = 6'h2F;
    sw_wr = 1'b1;
    repeat (3) step();
    sw_wr = 1'b0;
    repeat (15) step();
    vectors++; if (wr_seen !== 0) begin miscompares++; $display("FAIL glitch_ticks: got %0d want 0", wr_seen); end
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL glitch_count: got %0d want 1", count); end
    clear_seen();
    sw_data = 6'h0B;
    sw_wr = 1'b1;
    repeat (2) step();
    sw_wr = 1'b0;
    repeat (2) step();
    sw_wr = 1'b1;
    repeat (12) step();
    sw_wr = 1'b0;
    repeat (12) step();
    vectors++; if (wr_seen !== 1) begin miscompares++; $display("FAIL bounce_ticks: got %0d want 1", wr_seen); end
    vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL bounce_count: got %0d want 2", count); end
    vectors++; if (r_data !== 6'h15) begin miscompares++; $display("FAIL bounce_rdata: got %h want 15", r_data); end
  endtask

  task automatic test_fill_drain();
    logic [5:0] d;
    for (int i = 1; i <= 8; i++) begin
      d = 6'(i);
      press(1'b0, 1'b1, d);
      vectors++; if (count !== 4'(i)) begin miscompares++; $display("FAIL fill_count i=%0d: got %0d want %0d", i, count, i); end
    end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
    press(1'b0, 1'b1, 6'h3F);
    vectors++; if (wr_seen !== 1) begin miscompares++; $display("FAIL ovf_tick: got %0d want 1", wr_seen); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d want 8", count); end
    vectors++; if (ovf !== FLAG_EXP) begin miscompares++; $display("FAIL ovf_flag: got %b want %b", ovf, FLAG_EXP); end
    vectors++; if (udf !== 1'b0) begin miscompares++; $display("FAIL ovf_udf: got %b want 0", udf); end
    for (int i = 1; i <= 8; i++) begin
      d = 6'(i);
      vectors++; if (r_data !== d) begin miscompares++; $display("FAIL drain_rdata i=%0d: got %h want %h", i, r_data, d); end
      press(1'b1, 1'b0, 6'h00);
      vectors++; if (count !== 4'(8 - i)) begin miscompares++; $display("FAIL drain_count i=%0d: got %0d want %0d", i, count, 8 - i); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty); end
    vectors++; if (r_data !== 6'h00) begin miscompares++; $display("FAIL drain_rdata_empty: got %h want 00", r_data); end
    vectors++; if (udf !== 1'b0) begin miscompares++; $display("FAIL drain_udf_early: got %b want 0", udf); end
    press(1'b1, 1'b0, 6'h00);
    vectors++; if (udf !== FLAG_EXP) begin miscompares++; $display("FAIL udf_flag: got %b want %b", udf, FLAG_EXP); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL udf_count: got %0d want 0", count); end
    vectors++; if (ovf !== FLAG_EXP) begin miscompares++; $display("FAIL udf_ovf_sticky: got %b want %b", ovf, FLAG_EXP); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] d;
    for (int i = 1; i <= 8; i++) begin
      d = 6'(i);
      press(1'b0, 1'b1, d);
    end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL sim_prefill: got %0d want 8", count); end
    press(1'b1, 1'b1, 6'h2A);
    vectors++; if (both_seen !== 1) begin miscompares++; $display("FAIL sim_aligned: got %0d want 1", both_seen); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL sim_count: got %0d want 8", count); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL sim_full: got %b want 1", full); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sim_ovf: got %b want 0", ovf); end
    vectors++; if (r_data !== 6'h02) begin miscompares++; $display("FAIL sim_rdata: got %h want 02", r_data); end
    for (int i = 0; i < 8; i++) begin
      d = (i < 7) ? 6'(i + 2) : 6'h2A;
      vectors++; if (r_data !== d) begin miscompares++; $display("FAIL sim_drain i=%0d: got %h want %h", i, r_data, d); end
      press(1'b1, 1'b0, 6'h00);
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL sim_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid_press();
    logic [5:0] d;
    for (int i = 1; i <= 5; i++) begin
      d = 6'(i);
      press(1'b0, 1'b1, d);
    end
    vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL mid_prefill: got %0d want 5", count); end
    clear_seen();
    sw_data = 6'h33;
    sw_wr = 1'b1;
    repeat (6) step();
    vectors++; if (wr_seen !== 0) begin miscompares++; $display("FAIL mid_early_tick: got %0d want 0", wr_seen); end
    reset = 1'b1;
    #1;
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL mid_reset_count: got %0d want 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL mid_reset_empty: got %b want 1", empty); end
    repeat (2) step();
    reset = 1'b0;
    clear_seen();
    repeat (14) step();
    vectors++; if (wr_seen !== 1) begin miscompares++; $display("FAIL mid_after_tick: got %0d want 1", wr_seen); end
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL mid_after_count: got %0d want 1", count); end
    vectors++; if (r_data !== 6'h33) begin miscompares++; $display("FAIL mid_after_rdata: got %h want 33", r_data); end
    sw_wr = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clear_seen();
    reset = 1'b1;
    sw_rd = 1'b0;
    sw_wr = 1'b0;
    sw_data = 6'h00;
    test_reset();
    test_latency();
    test_glitch();
    apply_reset();
    test_fill_drain();
    apply_reset();
    test_simultaneous();
    apply_reset();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
